// File: rtl/kbd_evq.sv
// PS/2 set-2 scan byte decoder with modifier tracking and a memory-mapped event FIFO.
// Events are 14 bits wide: {caps, alt, ctrl, shift, keyup, extend, code}.
module kbd_evq #(
  parameter int FIFO_AW   = 4,
  parameter bit KEYUP_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        rw,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic        scan_valid,
  input  logic [7:0]  scan_code,
  output logic        irq
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = DEPTH[FIFO_AW:0];

  // Scan path has no backpressure: a byte is consumed in the cycle scan_valid is high.
  logic [13:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_head;
  logic [FIFO_AW-1:0] r_tail;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;
  logic               r_pend_up;
  logic               r_pend_ext;
  logic               r_lshift, r_rshift;
  logic               r_lctrl, r_rctrl;
  logic               r_lalt, r_ralt;
  logic               r_caps;
  logic               r_caps_held;
  logic               r_irq_en;
  logic               r_report_keyup;
  logic [31:0]        r_rdata;
  logic               r_irq;

  logic        w_shift, w_ctrl, w_alt;
  logic        w_empty, w_full;
  logic        w_rd, w_wr;
  logic [1:0]  w_sel;
  logic        w_data_rd, w_ctrl_wr, w_flush, w_clr_ovf;
  logic        w_prefix, w_ev_done;
  logic [13:0] w_event;
  logic        w_push_req, w_push, w_pop, w_ovf_set;
  logic [8:0]  w_count9;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_shift = r_lshift | r_rshift;
  assign w_ctrl  = r_lctrl | r_rctrl;
  assign w_alt   = r_lalt | r_ralt;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  assign w_rd      = ena & ~rw;
  assign w_wr      = ena & rw;
  assign w_sel     = addr[3:2];
  assign w_data_rd = w_rd & (w_sel == 2'd0);
  assign w_ctrl_wr = w_wr & (w_sel == 2'd2);
  assign w_flush   = w_ctrl_wr & wdata[3];
  assign w_clr_ovf = w_ctrl_wr & wdata[2];

  assign w_prefix  = (scan_code == 8'hF0) || (scan_code == 8'hE0);
  assign w_ev_done = scan_valid & ~w_prefix;
  assign w_event   = {r_caps, w_alt, w_ctrl, w_shift, r_pend_up, r_pend_ext, scan_code};

  // A full FIFO still accepts a push when the same cycle pops; flush discards everything.
  assign w_push_req = w_ev_done & (r_report_keyup | ~r_pend_up);
  assign w_pop      = w_data_rd & ~w_empty & ~w_flush;
  assign w_push     = w_push_req & (~w_full | w_pop) & ~w_flush;
  assign w_ovf_set  = w_push_req & w_full & ~w_pop & ~w_flush;

  always_comb begin
    w_count9 = '0;
    w_count9[FIFO_AW:0] = r_count;
  end

  assign w_status = {16'b0, r_caps, w_alt, w_ctrl, w_shift, r_ovf, w_full, w_empty, w_count9};
  assign w_unused = ^{addr[31:4], addr[1:0], wdata[31:4]};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_event;
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf          <= 1'b0;
      r_irq_en       <= 1'b0;
      r_report_keyup <= KEYUP_RST;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
      if (w_ctrl_wr) begin
        r_irq_en       <= wdata[0];
        r_report_keyup <= wdata[1];
      end
    end
  end

  // Modifier state changes after the event has captured the pre-update values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_up   <= 1'b0;
      r_pend_ext  <= 1'b0;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_lalt      <= 1'b0;
      r_ralt      <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (scan_valid) begin
      if (scan_code == 8'hF0) begin
        r_pend_up <= 1'b1;
      end else if (scan_code == 8'hE0) begin
        r_pend_ext <= 1'b1;
      end else begin
        r_pend_up  <= 1'b0;
        r_pend_ext <= 1'b0;
        case (scan_code)
          8'h12: r_lshift <= ~r_pend_up;
          8'h59: r_rshift <= ~r_pend_up;
          8'h14: if (r_pend_ext) r_rctrl <= ~r_pend_up; else r_lctrl <= ~r_pend_up;
          8'h11: if (r_pend_ext) r_ralt <= ~r_pend_up; else r_lalt <= ~r_pend_up;
          8'h58: begin
            if (r_pend_up) begin
              r_caps_held <= 1'b0;
            end else if (!r_caps_held) begin
              r_caps      <= ~r_caps;
              r_caps_held <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= r_irq_en & ~w_empty;
      if (w_rd) begin
        case (w_sel)
          2'd0:    r_rdata <= w_pop ? {18'b0, r_mem[r_head]} : 32'b0;
          2'd1:    r_rdata <= w_status;
          2'd2:    r_rdata <= {30'b0, r_report_keyup, r_irq_en};
          default: r_rdata <= '0;
        endcase
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: tb/tb_kbd_evq.sv
// Directed bench for kbd_evq with a 4-entry FIFO; bus reads feed an expected queue
// that a negedge monitor drains against rdata.
module tb_kbd_evq;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        irq;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  logic        rd_seen;

  kbd_evq #(.FIFO_AW(2), .KEYUP_RST(1'b0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rw(rw), .addr(addr), .rdata(rdata),
    .wdata(wdata), .scan_valid(scan_valid), .scan_code(scan_code), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, actual time %0t, required below 200000", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at one edge presents rdata until the next edge.
  always @(posedge clk) rd_seen <= ena & ~rw & ~rst;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rdata_unexpected: actual 0x%08h required no read", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // Driver tasks: entered just after a rising edge, leave just after the next one.
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    ena = 1'b1; rw = 1'b1; addr = {28'b0, a, 2'b00}; wdata = d;
    @(posedge clk); #1;
    ena = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    ena = 1'b1; rw = 1'b0; addr = {28'b0, a, 2'b00};
    @(posedge clk); #1;
    ena = 1'b0;
  endtask

  task automatic rd_with_scan(input logic [31:0] exp, input logic [7:0] b);
    exp_q.push_back(exp);
    ena = 1'b1; rw = 1'b0; addr = 32'h0;
    scan_code = b; scan_valid = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0; scan_valid = 1'b0;
  endtask

  task automatic wr_with_scan(input logic [31:0] d, input logic [7:0] b);
    ena = 1'b1; rw = 1'b1; addr = 32'h8; wdata = d;
    scan_code = b; scan_valid = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0; rw = 1'b0; scan_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; ena = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    scan_valid = 1'b0; scan_code = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_rd(2'd1, 32'h0000_0200);
    bus_rd(2'd2, 32'h0000_0000);

    // Single make code
    send(8'h1C);
    bus_rd(2'd0, 32'h0000_001C);
    bus_rd(2'd1, 32'h0000_0200);
    @(posedge clk); #1;
    check("idle_rdata", rdata, 32'h0);

    // Shifted key with break reporting on
    bus_wr(2'd2, 32'h2);
    bus_rd(2'd2, 32'h2);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    bus_rd(2'd1, 32'h0000_0404);
    bus_rd(2'd0, 32'h0000_0012);
    bus_rd(2'd0, 32'h0000_041C);
    bus_rd(2'd0, 32'h0000_061C);
    bus_rd(2'd0, 32'h0000_0612);
    bus_rd(2'd1, 32'h0000_0200);

    // Extended break: dropped without reporting, kept with it
    bus_wr(2'd2, 32'h0);
    send(8'hE0); send(8'hF0); send(8'h75);
    bus_rd(2'd1, 32'h0000_0200);
    bus_wr(2'd2, 32'h2);
    send(8'hE0); send(8'hF0); send(8'h75);
    bus_rd(2'd0, 32'h0000_0375);
    bus_rd(2'd1, 32'h0000_0200);

    // Overflow on a 4-entry FIFO
    bus_wr(2'd2, 32'h0);
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
    bus_rd(2'd1, 32'h0000_0C04);
    bus_wr(2'd2, 32'h4);
    bus_rd(2'd1, 32'h0000_0404);
    bus_rd(2'd0, 32'h0000_001C);
    bus_rd(2'd0, 32'h0000_001B);
    bus_rd(2'd0, 32'h0000_0023);
    bus_rd(2'd0, 32'h0000_002B);
    bus_rd(2'd0, 32'h0000_0000);
    bus_rd(2'd1, 32'h0000_0200);

    // Caps lock toggling and interrupt
    bus_wr(2'd2, 32'h1);
    send(8'h58);
    bus_rd(2'd1, 32'h0000_8001);
    check("irq_set", {31'b0, irq}, 32'h1);
    send(8'h58);
    bus_rd(2'd1, 32'h0000_8002);
    send(8'hF0); send(8'h58);
    bus_rd(2'd1, 32'h0000_8002);
    send(8'h58);
    bus_rd(2'd1, 32'h0000_0003);
    bus_rd(2'd0, 32'h0000_0058);
    bus_rd(2'd0, 32'h0000_2058);
    check("irq_before_last", {31'b0, irq}, 32'h1);
    bus_rd(2'd0, 32'h0000_2058);
    check("irq_at_last_pop", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Push coincident with pop on a one-entry FIFO
    bus_wr(2'd2, 32'h0);
    send(8'h1C);
    rd_with_scan(32'h0000_001C, 8'h1B);
    bus_rd(2'd1, 32'h0000_0001);
    bus_rd(2'd0, 32'h0000_001B);
    bus_rd(2'd1, 32'h0000_0200);

    // Flush with a coincident push, ignored writes, reserved read
    send(8'h1C); send(8'h1B);
    wr_with_scan(32'h8, 8'h23);
    bus_rd(2'd1, 32'h0000_0200);
    bus_rd(2'd0, 32'h0000_0000);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd(2'd1, 32'h0000_0200);
    bus_rd(2'd3, 32'h0000_0000);
    bus_rd(2'd2, 32'h0000_0000);

    // Ctrl held by right side after left release
    send(8'h14); send(8'hE0); send(8'h14); send(8'hF0); send(8'h14);
    bus_rd(2'd1, 32'h0000_2002);
    send(8'hE0); send(8'hF0); send(8'h14);
    bus_rd(2'd1, 32'h0000_0002);
    bus_rd(2'd0, 32'h0000_0014);
    bus_rd(2'd0, 32'h0000_0914);

    // Alt modifies the next key
    send(8'h11); send(8'h1C);
    bus_rd(2'd1, 32'h0000_4002);
    send(8'hF0); send(8'h11);
    bus_rd(2'd1, 32'h0000_0002);
    bus_rd(2'd0, 32'h0000_0011);
    bus_rd(2'd0, 32'h0000_101C);

    // Left shift holds after right shift released
    send(8'h12); send(8'h59); send(8'hF0); send(8'h59);
    bus_rd(2'd1, 32'h0000_1002);
    send(8'hF0); send(8'h12);
    bus_rd(2'd1, 32'h0000_0002);
    bus_rd(2'd0, 32'h0000_0012);
    bus_rd(2'd0, 32'h0000_0459);

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_evq.md
KBD_EVQ -- requirements
Module: kbd_evq

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning FIFO depth = 2**FIFO_AW events (legal 2..8).
REQ-002 SHALL have parameter KEYUP_RST, default 0, meaning reset value of CTRL.report_keyup.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port ena  input  1  bus access strobe, one cycle per access.
REQ-006 SHALL have port rw  input  1  1=write, 0=read.
REQ-007 SHALL have port addr  input  32  byte address; only addr[3:2] decoded (0 DATA, 1 STATUS, 2 CTRL, 3 reserved).
REQ-008 SHALL have port rdata  output  32  registered read data.
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port scan_valid  input  1  one-cycle pulse, one PS/2 byte available (from ps2_keyboard ready).
REQ-011 SHALL have port scan_code  input  8  PS/2 set-2 byte, valid with scan_valid.
REQ-012 SHALL have port irq  output  1  level interrupt request.

Function
REQ-013 SHALL treat byte 0xF0 as keyup prefix and 0xE0 as extend prefix: set pending flag, no event.
REQ-014 SHALL on any other byte form event {18'b0, caps, alt, ctrl, shift, keyup, extend, code[7:0]} with modifier bits taken before this byte's update, then clear both pending flags.
REQ-015 SHALL track shift (0x12, 0x59), ctrl (0x14, E0 0x14), alt (0x11, E0 0x11): make sets, break clears; either side holds the bit.
REQ-016 SHALL toggle caps on 0x58 make only when caps key not already held (typematic repeats ignored); break clears held flag.
REQ-017 SHALL discard break events (keyup=1) when CTRL.report_keyup=0; modifier tracking still applies.
REQ-018 SHALL push the event into the FIFO at the same clk edge that samples the final byte.
REQ-019 SHALL, FIFO full and no simultaneous pop: drop the new event, set STATUS.overflow (sticky).
REQ-020 SHALL, full with simultaneous pop: accept push; count unchanged.
REQ-021 SHALL, on read of DATA (ena & !rw & addr[3:2]=0): rdata at next edge = head-of-queue event and pop; if empty rdata=0, no pop, count unchanged.
REQ-022 SHALL, push and pop same cycle while non-empty: both occur, count unchanged; pop while empty with push: rdata=0, new event retained.
REQ-023 SHALL return STATUS = {16'b0, caps, alt, ctrl, shift, overflow, full, empty, count[8:0]} packed from bit 0, count width FIFO_AW+1.
REQ-024 SHALL have CTRL bits: [0] irq_en, [1] report_keyup (R/W); [2] clr_ovf, [3] flush (write-1 pulse, read 0).
REQ-025 SHALL on flush empty the FIFO that edge; a push in the same cycle is discarded.
REQ-026 SHALL drive rdata=0 in any cycle without a read access; writes to DATA/STATUS/reserved ignored, reserved reads 0.
REQ-027 SHALL drive irq = irq_en & !empty, registered from state (no combinational path from bus).
REQ-028 SHALL use pointer wrap-around modulo 2**FIFO_AW with separate count; no ready/backpressure to the PS/2 source.

Reset
REQ-029 SHALL on rst: head, tail, count, overflow, pending flags, shift, ctrl, alt, caps, caps_held=0; irq_en=0; report_keyup=KEYUP_RST; rdata=0; irq=0.
REQ-030 SHALL let rst override bus access and scan_valid in the same cycle; FIFO contents need not be cleared.

Verification
REQ-031 SHALL verify: bytes 0x1C -> DATA read returns 0x0000001C, STATUS empty=1 afterwards.
REQ-032 SHALL verify: 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12 with report_keyup=1 -> events 0x012, 0x41C, 0x61C, 0x612; STATUS.shift=0 at end.
REQ-033 SHALL verify: FIFO_AW=2, five makes without reads -> count=4, full=1, overflow=1, fifth lost; write CTRL 0x4 -> overflow=0.
REQ-034 SHALL verify: 0xE0, 0xF0, 0x75 with report_keyup=0 -> no event; with report_keyup=1 -> event 0x375.
REQ-035 SHALL verify: 0x58, 0x58 (repeat), 0xF0 0x58, 0x58 -> caps 1, 1, 1, 0; irq_en=1 -> irq high while non-empty, low one cycle after last pop.
REQ-036 SHALL verify: scan_valid pulse coincident with DATA read on one-entry FIFO -> old event returned, count stays 1, new event read next.
